// File: rtl/uart_row_loader.sv
// -----------------------------------------------------------------------------
// uart_row_loader
//   Receives row packets from a UART receiver and writes them into a frame
//   buffer. A packet is: Y low byte, Y high byte, ROW_BYTES data bytes, and
//   STOP_BYTE. Every received byte is answered through a 2-entry answer queue
//   that feeds a UART transmitter. Failed packets answer ACK_FAIL followed by
//   the number of missing data bytes.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx_data      received byte, valid while rx_done=1
//   rx_done      one-cycle strobe per received byte
//   tx_data      answer byte, stable from tx_start until the transmitter is idle
//   tx_start     one-cycle start strobe to the transmitter
//   tx_busy      transmitter busy
//   wr_en        frame-buffer write strobe
//   wr_addr      frame-buffer byte address (17 bit)
//   wr_data      frame-buffer write data
//   row_done     one-cycle pulse when a packet completes with ACK_OK
//   err_overrun  sticky, set when an answer is dropped on a full queue
// -----------------------------------------------------------------------------
module uart_row_loader #(
  parameter int unsigned ROW_BYTES      = 240,
  parameter int unsigned HEIGHT         = 480,
  parameter logic [7:0]  STOP_BYTE      = 8'hDD,
  parameter logic [7:0]  ACK_ROW        = 8'hCC,
  parameter logic [7:0]  ACK_DATA       = 8'hAA,
  parameter logic [7:0]  ACK_OK         = 8'hFF,
  parameter logic [7:0]  ACK_FAIL       = 8'h11,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        row_done,
  output logic        err_overrun
);

  localparam int IDX_W = $clog2(ROW_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    Y_LO  = 3'd0,
    Y_HI  = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    FAIL2 = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        y_lo_r, y_lo_s;
  logic [16:0]       base_r, base_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [7:0]        fail_cnt_r, fail_cnt_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic [1:0][7:0]   q_data_r, q_data_s;
  logic [1:0]        q_cnt_r, q_cnt_s;
  logic [1:0]        guard_r, guard_s;
  logic [7:0]        tx_data_r, tx_data_s;
  logic              tx_start_r, tx_start_s;
  logic              wr_en_r, wr_en_s;
  logic [16:0]       wr_addr_r, wr_addr_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              row_done_r, row_done_s;
  logic              err_overrun_r, err_overrun_s;

  logic [15:0]       y_s;
  logic              timed_s;
  logic              timeout_s;
  logic              launch_s;
  logic              push0_s, push1_s;
  logic [7:0]        push0_data_s, push1_data_s;

  // Packet FSM: next state, row bookkeeping, frame-buffer write and answers to queue.
  always_comb begin
    state_s      = state_r;
    y_lo_s       = y_lo_r;
    base_s       = base_r;
    idx_s        = idx_r;
    fail_cnt_s   = fail_cnt_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    row_done_s   = 1'b0;
    push0_s      = 1'b0;
    push0_data_s = 8'h00;
    push1_s      = 1'b0;
    push1_data_s = 8'h00;
    y_s          = {rx_data, y_lo_r};
    timed_s      = (state_r == Y_HI) || (state_r == DATA) || (state_r == STOP);
    // A byte arriving in the expiry cycle cancels the timeout.
    timeout_s    = timed_s && !rx_done && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    case (state_r)
      Y_LO: begin
        if (rx_done) begin
          y_lo_s       = rx_data;
          push0_s      = 1'b1;
          push0_data_s = ACK_ROW;
          state_s      = Y_HI;
        end else begin
          state_s = Y_LO;
        end
      end
      Y_HI: begin
        if (rx_done) begin
          push0_s      = 1'b1;
          push0_data_s = ACK_ROW;
          if (y_s < 16'(HEIGHT)) begin
            base_s  = 17'(32'(y_s) * 32'(ROW_BYTES));
            idx_s   = '0;
            state_s = DATA;
          end else begin
            push1_s      = 1'b1;
            push1_data_s = ACK_FAIL;
            fail_cnt_s   = 8'(ROW_BYTES);
            state_s      = FAIL2;
          end
        end else if (timeout_s) begin
          push0_s      = 1'b1;
          push0_data_s = ACK_FAIL;
          fail_cnt_s   = 8'(ROW_BYTES);
          state_s      = FAIL2;
        end else begin
          state_s = Y_HI;
        end
      end
      DATA: begin
        if (rx_done) begin
          wr_en_s      = 1'b1;
          wr_addr_s    = base_r + 17'(idx_r);
          wr_data_s    = rx_data;
          push0_s      = 1'b1;
          push0_data_s = ACK_DATA;
          idx_s        = idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(ROW_BYTES - 1)) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else if (timeout_s) begin
          push0_s      = 1'b1;
          push0_data_s = ACK_FAIL;
          fail_cnt_s   = 8'(ROW_BYTES - 32'(idx_r));
          state_s      = FAIL2;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (rx_done) begin
          if (rx_data == STOP_BYTE) begin
            push0_s      = 1'b1;
            push0_data_s = ACK_OK;
            row_done_s   = 1'b1;
            state_s      = Y_LO;
          end else begin
            push0_s      = 1'b1;
            push0_data_s = ACK_FAIL;
            fail_cnt_s   = 8'h00;
            state_s      = FAIL2;
          end
        end else if (timeout_s) begin
          push0_s      = 1'b1;
          push0_data_s = ACK_FAIL;
          fail_cnt_s   = 8'h00;
          state_s      = FAIL2;
        end else begin
          state_s = STOP;
        end
      end
      FAIL2: begin
        // Second half of a failure answer; a byte landing here already starts the next packet.
        push0_s      = 1'b1;
        push0_data_s = fail_cnt_r;
        if (rx_done) begin
          y_lo_s       = rx_data;
          push1_s      = 1'b1;
          push1_data_s = ACK_ROW;
          state_s      = Y_HI;
        end else begin
          state_s = Y_LO;
        end
      end
      default: begin
        state_s = Y_LO;
      end
    endcase

    if (!timed_s || rx_done || timeout_s) begin
      to_cnt_s = '0;
    end else begin
      to_cnt_s = to_cnt_r + TO_W'(1);
    end
  end

  // Answer queue: pop on launch first so a push in the same cycle can reuse the slot.
  always_comb begin
    launch_s      = (q_cnt_r != 2'd0) && !tx_busy && (guard_r == 2'd0);
    q_data_s      = q_data_r;
    q_cnt_s       = q_cnt_r;
    err_overrun_s = err_overrun_r;
    tx_start_s    = launch_s;
    tx_data_s     = tx_data_r;

    if (launch_s) begin
      tx_data_s   = q_data_r[0];
      q_data_s[0] = q_data_r[1];
      q_cnt_s     = q_cnt_r - 2'd1;
      guard_s     = 2'd2;
    end else if (guard_r != 2'd0) begin
      guard_s = guard_r - 2'd1;
    end else begin
      guard_s = guard_r;
    end

    if (push0_s) begin
      if (q_cnt_s != 2'd2) begin
        q_data_s[q_cnt_s[0]] = push0_data_s;
        q_cnt_s              = q_cnt_s + 2'd1;
      end else begin
        err_overrun_s = 1'b1;
      end
    end else begin
      q_cnt_s = q_cnt_s;
    end

    if (push1_s) begin
      if (q_cnt_s != 2'd2) begin
        q_data_s[q_cnt_s[0]] = push1_data_s;
        q_cnt_s              = q_cnt_s + 2'd1;
      end else begin
        err_overrun_s = 1'b1;
      end
    end else begin
      q_cnt_s = q_cnt_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= Y_LO;
      y_lo_r        <= 8'h00;
      base_r        <= 17'd0;
      idx_r         <= '0;
      fail_cnt_r    <= 8'h00;
      to_cnt_r      <= '0;
      q_data_r      <= '0;
      q_cnt_r       <= 2'd0;
      guard_r       <= 2'd0;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= 17'd0;
      wr_data_r     <= 8'h00;
      row_done_r    <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      y_lo_r        <= y_lo_s;
      base_r        <= base_s;
      idx_r         <= idx_s;
      fail_cnt_r    <= fail_cnt_s;
      to_cnt_r      <= to_cnt_s;
      q_data_r      <= q_data_s;
      q_cnt_r       <= q_cnt_s;
      guard_r       <= guard_s;
      tx_data_r     <= tx_data_s;
      tx_start_r    <= tx_start_s;
      wr_en_r       <= wr_en_s;
      wr_addr_r     <= wr_addr_s;
      wr_data_r     <= wr_data_s;
      row_done_r    <= row_done_s;
      err_overrun_r <= err_overrun_s;
    end
  end

  assign tx_data     = tx_data_r;
  assign tx_start    = tx_start_r;
  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign row_done    = row_done_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_uart_row_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_row_loader
//   Drives row packets byte by byte, models the UART transmitter (busy starts
//   two cycles after tx_start), records answers and frame-buffer writes, and
//   compares them against expectations built from the packet rules.
// -----------------------------------------------------------------------------
module tb_uart_row_loader;

  localparam int RB  = 240;
  localparam int HT  = 480;
  localparam int TO  = 400;
  localparam int GAP = 30;
  localparam int TXL = 12;

  typedef logic [7:0]  bq_t[$];
  typedef logic [24:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy_hold = 1'b0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        row_done;
  logic        err_overrun;

  int  tx_cnt_r = 0;
  bq_t ans_q;
  wq_t wr_q;
  int  rd_cnt = 0;
  int  addr_bad = 0;
  int  proto_bad = 0;
  int  pass_cnt = 0;
  int  total_cnt = 0;

  always #5 clk = ~clk;

  assign tx_busy = (tx_cnt_r != 0 && tx_cnt_r <= TXL) || busy_hold;

  uart_row_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_done(row_done), .err_overrun(err_overrun)
  );

  // Transmitter model and output recorder.
  always @(negedge clk) begin
    if (tx_start) begin
      ans_q.push_back(tx_data);
      if (tx_cnt_r != 0) proto_bad <= proto_bad + 1;
      tx_cnt_r <= TXL + 2;
    end else if (tx_cnt_r != 0) begin
      tx_cnt_r <= tx_cnt_r - 1;
    end
    if (wr_en) begin
      wr_q.push_back({wr_addr, wr_data});
      if (int'(wr_addr) >= RB * HT) addr_bad <= addr_bad + 1;
    end
    if (row_done) rd_cnt <= rd_cnt + 1;
  end

  function automatic int diff_b(input bq_t got, input int from, input bq_t exp);
    if (got.size() - from != exp.size()) return -2;
    for (int i = 0; i < exp.size(); i++) if (got[from + i] !== exp[i]) return i;
    return -1;
  endfunction

  function automatic int diff_w(input wq_t got, input int from, input wq_t exp);
    if (got.size() - from != exp.size()) return -2;
    for (int i = 0; i < exp.size(); i++) if (got[from + i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (GAP - 2) @(negedge clk);
  endtask

  task automatic send_packet(input int y, input bq_t dat, input bit with_stop, input logic [7:0] stop);
    logic [15:0] yv;
    yv = 16'(y);
    send_byte(yv[7:0]);
    send_byte(yv[15:8]);
    foreach (dat[i]) send_byte(dat[i]);
    if (with_stop) send_byte(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tx_start, tx_data} !== 9'h000)
      $display("FAIL reset_tx: got tx_start=%b tx_data=%h want 0/00", tx_start, tx_data);
    else pass_cnt++;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, row_done, err_overrun} !== 28'h0)
      $display("FAIL reset_wr: got wr_en=%b addr=%0d data=%h row_done=%b ovr=%b want all 0",
               wr_en, wr_addr, wr_data, row_done, err_overrun);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Full good row at Y=257, plus a random valid row.
  task automatic test_good_row();
    for (int t = 0; t < 2; t++) begin
      int a0, w0, r0, p0, d, y;
      bq_t dat, ea;
      wq_t ew;
      y = (t == 0) ? 257 : int'($urandom_range(HT - 1, 0));
      a0 = ans_q.size(); w0 = wr_q.size(); r0 = rd_cnt; p0 = proto_bad;
      ea.push_back(8'hCC); ea.push_back(8'hCC);
      for (int i = 0; i < RB; i++) begin
        dat.push_back(8'($urandom));
        ea.push_back(8'hAA);
        ew.push_back({17'(y * RB + i), dat[i]});
      end
      ea.push_back(8'hFF);
      send_packet(y, dat, 1'b1, 8'hDD);
      repeat (60) @(negedge clk);
      d = diff_b(ans_q, a0, ea);
      total_cnt++;
      if (d != -1) $display("FAIL good_row_answers y=%0d: diff at %0d, got %0d answers want %0d", y, d, ans_q.size() - a0, ea.size());
      else pass_cnt++;
      d = diff_w(wr_q, w0, ew);
      total_cnt++;
      if (d != -1) $display("FAIL good_row_writes y=%0d: diff at %0d, got %0d writes want %0d", y, d, wr_q.size() - w0, ew.size());
      else pass_cnt++;
      total_cnt++;
      if (rd_cnt - r0 !== 1) $display("FAIL good_row_done y=%0d: got %0d pulses want 1", y, rd_cnt - r0);
      else pass_cnt++;
      total_cnt++;
      if (proto_bad - p0 !== 0) $display("FAIL good_row_txproto: got %0d violations want 0", proto_bad - p0);
      else pass_cnt++;
    end
  endtask

  // Silence during DATA, then a second short packet that also times out.
  task automatic test_timeout();
    int n [2] = '{100, 2};
    int yy [2] = '{0, 3};
    for (int t = 0; t < 2; t++) begin
      int a0, w0, r0, d;
      bq_t dat, ea;
      wq_t ew;
      a0 = ans_q.size(); w0 = wr_q.size(); r0 = rd_cnt;
      ea.push_back(8'hCC); ea.push_back(8'hCC);
      for (int i = 0; i < n[t]; i++) begin
        dat.push_back(8'($urandom));
        ea.push_back(8'hAA);
        ew.push_back({17'(yy[t] * RB + i), dat[i]});
      end
      ea.push_back(8'h11);
      ea.push_back(8'(RB - n[t]));
      send_packet(yy[t], dat, 1'b0, 8'h00);
      repeat (TO + 60) @(negedge clk);
      d = diff_b(ans_q, a0, ea);
      total_cnt++;
      if (d != -1) $display("FAIL timeout_answers n=%0d: diff at %0d, got %0d answers want %0d", n[t], d, ans_q.size() - a0, ea.size());
      else pass_cnt++;
      d = diff_w(wr_q, w0, ew);
      total_cnt++;
      if (d != -1) $display("FAIL timeout_writes n=%0d: diff at %0d, got %0d writes want %0d", n[t], d, wr_q.size() - w0, ew.size());
      else pass_cnt++;
      total_cnt++;
      if (rd_cnt - r0 !== 0) $display("FAIL timeout_row_done: got %0d pulses want 0", rd_cnt - r0);
      else pass_cnt++;
    end
  endtask

  // Bytes landing exactly in the expiry cycle must win over the timeout.
  task automatic test_timeout_race();
    int a0, w0, d;
    logic [7:0] b;
    bq_t ea;
    wq_t ew;
    a0 = ans_q.size(); w0 = wr_q.size();
    b = 8'($urandom);
    ea = '{8'hCC, 8'hCC, 8'hAA, 8'h11, 8'(RB - 1)};
    ew.push_back({17'(7 * RB), b});
    send_byte(8'd7);
    repeat (TO - GAP) @(negedge clk);
    send_byte(8'd0);
    repeat (TO - GAP) @(negedge clk);
    send_byte(b);
    repeat (TO + 60) @(negedge clk);
    d = diff_b(ans_q, a0, ea);
    total_cnt++;
    if (d != -1) $display("FAIL timeout_race_answers: diff at %0d, got %0d answers want %0d", d, ans_q.size() - a0, ea.size());
    else pass_cnt++;
    d = diff_w(wr_q, w0, ew);
    total_cnt++;
    if (d != -1) $display("FAIL timeout_race_writes: diff at %0d, got %0d writes want 1", d, wr_q.size() - w0);
    else pass_cnt++;
  endtask

  // Out-of-range Y: Y=480 and a random larger Y.
  task automatic test_bad_y();
    for (int t = 0; t < 2; t++) begin
      int a0, w0, p0, d, y;
      bq_t ea, none;
      y = (t == 0) ? HT : int'($urandom_range(65535, HT + 1));
      a0 = ans_q.size(); w0 = wr_q.size(); p0 = proto_bad;
      ea = '{8'hCC, 8'hCC, 8'h11, 8'(RB)};
      send_packet(y, none, 1'b0, 8'h00);
      repeat (80) @(negedge clk);
      d = diff_b(ans_q, a0, ea);
      total_cnt++;
      if (d != -1) $display("FAIL bad_y_answers y=%0d: diff at %0d, got %0d answers want 4", y, d, ans_q.size() - a0);
      else pass_cnt++;
      total_cnt++;
      if (wr_q.size() - w0 !== 0) $display("FAIL bad_y_writes y=%0d: got %0d writes want 0", y, wr_q.size() - w0);
      else pass_cnt++;
      total_cnt++;
      if ({err_overrun, 8'(proto_bad - p0)} !== 9'h000)
        $display("FAIL bad_y_tx: got overrun=%b proto=%0d want 0/0", err_overrun, proto_bad - p0);
      else pass_cnt++;
    end
  endtask

  // Wrong terminator after a full row.
  task automatic test_bad_stop();
    int a0, w0, r0, d, y;
    bq_t dat, ea;
    wq_t ew;
    y = int'($urandom_range(HT - 1, 0));
    a0 = ans_q.size(); w0 = wr_q.size(); r0 = rd_cnt;
    ea.push_back(8'hCC); ea.push_back(8'hCC);
    for (int i = 0; i < RB; i++) begin
      dat.push_back(8'($urandom));
      ea.push_back(8'hAA);
      ew.push_back({17'(y * RB + i), dat[i]});
    end
    ea.push_back(8'h11); ea.push_back(8'h00);
    send_packet(y, dat, 1'b1, 8'h55);
    repeat (60) @(negedge clk);
    d = diff_b(ans_q, a0, ea);
    total_cnt++;
    if (d != -1) $display("FAIL bad_stop_answers: diff at %0d, got %0d answers want %0d", d, ans_q.size() - a0, ea.size());
    else pass_cnt++;
    d = diff_w(wr_q, w0, ew);
    total_cnt++;
    if (d != -1) $display("FAIL bad_stop_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size() - w0, ew.size());
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt - r0 !== 0) $display("FAIL bad_stop_row_done: got %0d pulses want 0", rd_cnt - r0);
    else pass_cnt++;
  endtask

  // Transmitter stalled over three data bytes: one answer lost, writes intact.
  task automatic test_overrun();
    int a0, w0, r0, p0, d, y;
    bq_t dat, ea;
    wq_t ew;
    y = int'($urandom_range(HT - 1, 0));
    a0 = ans_q.size(); w0 = wr_q.size(); r0 = rd_cnt; p0 = proto_bad;
    ea.push_back(8'hCC); ea.push_back(8'hCC);
    for (int i = 0; i < RB; i++) begin
      dat.push_back(8'($urandom));
      ew.push_back({17'(y * RB + i), dat[i]});
      if (i != 12) ea.push_back(8'hAA);
    end
    ea.push_back(8'hFF);
    send_byte(8'(y));
    send_byte(8'(y >> 8));
    for (int i = 0; i < RB; i++) begin
      if (i == 10) busy_hold = 1'b1;
      send_byte(dat[i]);
      if (i == 12) begin
        busy_hold = 1'b0;
        repeat (60) @(negedge clk);
      end
    end
    send_byte(8'hDD);
    repeat (60) @(negedge clk);
    total_cnt++;
    if (err_overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", err_overrun);
    else pass_cnt++;
    d = diff_b(ans_q, a0, ea);
    total_cnt++;
    if (d != -1) $display("FAIL overrun_answers: diff at %0d, got %0d answers want %0d", d, ans_q.size() - a0, ea.size());
    else pass_cnt++;
    d = diff_w(wr_q, w0, ew);
    total_cnt++;
    if (d != -1) $display("FAIL overrun_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size() - w0, ew.size());
    else pass_cnt++;
    total_cnt++;
    if ({8'(rd_cnt - r0), 8'(proto_bad - p0)} !== 16'h0100)
      $display("FAIL overrun_misc: got row_done=%0d proto=%0d want 1/0", rd_cnt - r0, proto_bad - p0);
    else pass_cnt++;
  endtask

  // Reset in the middle of a row, then a clean row at Y=0.
  task automatic test_reset_mid();
    int a0, w0, r0, d;
    bq_t dat, ea;
    wq_t ew;
    for (int i = 0; i < 50; i++) dat.push_back(8'($urandom));
    send_packet(int'($urandom_range(HT - 1, 0)), dat, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({tx_start, tx_data, wr_en, wr_addr, wr_data, row_done, err_overrun} !== 37'h0)
      $display("FAIL reset_mid_outputs: got tx_start=%b tx_data=%h wr_en=%b addr=%0d data=%h row_done=%b ovr=%b want all 0",
               tx_start, tx_data, wr_en, wr_addr, wr_data, row_done, err_overrun);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a0 = ans_q.size(); w0 = wr_q.size(); r0 = rd_cnt;
    dat.delete();
    ea.push_back(8'hCC); ea.push_back(8'hCC);
    for (int i = 0; i < RB; i++) begin
      dat.push_back(8'($urandom));
      ea.push_back(8'hAA);
      ew.push_back({17'(i), dat[i]});
    end
    ea.push_back(8'hFF);
    repeat (TO + 20) @(negedge clk);
    send_packet(0, dat, 1'b1, 8'hDD);
    repeat (60) @(negedge clk);
    d = diff_b(ans_q, a0, ea);
    total_cnt++;
    if (d != -1) $display("FAIL reset_mid_answers: diff at %0d, got %0d answers want %0d", d, ans_q.size() - a0, ea.size());
    else pass_cnt++;
    d = diff_w(wr_q, w0, ew);
    total_cnt++;
    if (d != -1) $display("FAIL reset_mid_writes: diff at %0d, got %0d writes want %0d", d, wr_q.size() - w0, ew.size());
    else pass_cnt++;
    total_cnt++;
    if ({8'(rd_cnt - r0), 8'(addr_bad)} !== 16'h0100)
      $display("FAIL reset_mid_misc: got row_done=%0d addr_out_of_range=%0d want 1/0", rd_cnt - r0, addr_bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_row();
    test_timeout();
    test_timeout_race();
    test_bad_y();
    test_bad_stop();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
